// File: rtl/sd_cmd_resp_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_resp_rx_if
// Brief    : Arm/response bundle between the CMD transmitter side and the
//            SD CMD-line response receiver.
// Revision : 1.0
// ============================================================================
interface sd_cmd_resp_rx_if;
    logic         cmd_in;
    logic         start;
    logic         long_resp;
    logic         busy;
    logic         resp_valid;
    logic [135:0] resp_data;
    logic         timeout_err;
    logic         crc_err;
    logic         frame_err;

    modport master (
        output cmd_in, start, long_resp,
        input  busy, resp_valid, resp_data, timeout_err, crc_err, frame_err
    );

    modport slave (
        input  cmd_in, start, long_resp,
        output busy, resp_valid, resp_data, timeout_err, crc_err, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_resp_rx.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_resp_rx
// Brief    : SD CMD-line response deserializer (48/136-bit frames) with
//            framing, timeout and optional CRC7 check (SD_CMD_RESP_CRC_CHECK_EN).
// Revision : 1.0
// ============================================================================
module sd_cmd_resp_rx #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic             clk,
    input  logic             reset,
    sd_cmd_resp_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_busy;
    logic            w_valid;

    logic            r_long;
    logic [7:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [135:0]    r_data;
    logic            r_to_err;
    logic            r_frame_err;
    logic            w_crc_err;

    logic            w_last_bit;
    logic            w_to_last;
    logic            w_arm;

    assign w_arm      = (r_state == S_IDLE) && bus.start;
    assign w_last_bit = (r_bit_cnt == (r_long ? 8'd135 : 8'd47));
    assign w_to_last  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (!bus.cmd_in) begin
                    w_state_nxt = S_RECV;
                end else if (w_to_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RECV: begin
                w_busy = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift register, counters and framing/timeout flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_long      <= 1'b0;
            r_bit_cnt   <= 8'd0;
            r_to_cnt    <= '0;
            r_data      <= '0;
            r_to_err    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_long      <= bus.long_resp;
                        r_bit_cnt   <= 8'd0;
                        r_to_cnt    <= '0;
                        r_data      <= '0;
                        r_to_err    <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!bus.cmd_in) begin
                        r_data    <= {r_data[134:0], bus.cmd_in};
                        r_bit_cnt <= 8'd1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (w_to_last) begin
                            r_to_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    r_data    <= {r_data[134:0], bus.cmd_in};
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    if (((r_bit_cnt == 8'd1) && bus.cmd_in) ||
                        (w_last_bit && !bus.cmd_in)) begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic [6:0] r_crc;
    logic       r_crc_err;
    logic       w_fb;
    logic       w_crc_span;
    logic       w_sample;

    // Bit counter is still 0 while waiting, so it doubles as the start-bit position
    assign w_sample   = ((r_state == S_WAIT) && !bus.cmd_in) || (r_state == S_RECV);
    assign w_crc_span = r_long ? ((r_bit_cnt >= 8'd8) && (r_bit_cnt <= 8'd127))
                               : (r_bit_cnt <= 8'd39);
    assign w_fb       = r_crc[6] ^ bus.cmd_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc     <= 7'd0;
            r_crc_err <= 1'b0;
        end else if (w_arm) begin
            r_crc     <= 7'd0;
            r_crc_err <= 1'b0;
        end else begin
            if (w_sample && w_crc_span) begin
                r_crc <= {r_crc[5:3], r_crc[2] ^ w_fb, r_crc[1:0], w_fb};
            end
            // At the end bit the received CRC7 sits in the low seven shift bits
            if ((r_state == S_RECV) && w_last_bit) begin
                r_crc_err <= (r_data[6:0] != r_crc);
            end
        end
    end

    assign w_crc_err = r_crc_err;
`else
    assign w_crc_err = 1'b0;
`endif

    assign bus.busy        = w_busy;
    assign bus.resp_valid  = w_valid;
    assign bus.resp_data   = r_data;
    assign bus.timeout_err = r_to_err;
    assign bus.crc_err     = w_crc_err;
    assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: doc/sd_cmd_resp_rx.md
Name: sd_cmd_resp_rx

Overview:
Host-side receiver for the SD CMD line. It deserializes card responses arriving from the bidirectional pad's `out` pin while the pad is in input mode (`oen` low). It is armed by the command transmitter after the command end bit. It then detects the start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame, checks framing and CRC7, and reports timeout when no response arrives.

Parameters:
TIMEOUT_CYCLES, 64, maximum number of high CMD samples after arming before the start bit (N_CR limit)
TO_W, 7, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  SD clock; CMD line sampled on the rising edge, one bit per cycle
reset  input  1  synchronous, active-high reset
cmd_in  input  1  CMD line level, from bidir pad `out`
start  input  1  one-cycle arm pulse; ignored while busy
long_resp  input  1  sampled with start: 1 = 136-bit frame, 0 = 48-bit frame
busy  output  1  high from the cycle after accepted start until resp_valid
resp_valid  output  1  one-cycle pulse; response frame or timeout complete
resp_data  output  136  raw frame, last received bit at [0]; 48-bit frames occupy [47:0] with [135:48] zero
timeout_err  output  1  valid with resp_valid; no start bit within TIMEOUT_CYCLES
crc_err  output  1  valid with resp_valid; received CRC7 differs from computed CRC7
frame_err  output  1  valid with resp_valid; transmission bit not 0 or end bit not 1

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0, CRC register 0.
- Reset mid-frame: on the next edge everything returns to reset values. No resp_valid is emitted.
- Frame positions: p = 0 is the start bit (0).
  - p = 1 is the transmission bit (must be 0).
  - Short frame (48 bits): CRC covers p 0..39; CRC7 at p 40..46 (MSB first); end bit at p 47.
  - Long frame (136 bits): CRC covers p 8..127; CRC7 at p 128..134; end bit at p 135.
- CRC7 polynomial x^7+x^3+1, initial value 0, serial update:
  - fb = crc[6] ^ bit
  - crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}
- IDLE:
  - start=1 latches long_resp.
  - Clears resp_data, all error flags, bit counter, timeout counter and CRC.
  - Moves to WAIT_START.
- WAIT_START:
  - cmd_in=0: treat as p=0. Shift it in, feed the CRC, set bit_cnt=1, go to RECEIVE.
  - cmd_in=1: increment the timeout counter. On the TIMEOUT_CYCLES-th consecutive high sample, go to DONE with timeout_err=1.
- RECEIVE:
  - Each cycle: resp_data <= {resp_data[134:0], cmd_in}.
  - Feed the CRC while p is inside the CRC span; capture the received CRC bits at the CRC span.
  - Check p=1 and the end bit.
  - When p = frame_len-1 has been sampled, go to DONE.
- DONE (one cycle):
  - resp_valid=1 and busy=0; error outputs are valid this cycle.
  - Error outputs hold until the next accepted start.
  - resp_data holds until the next accepted start.
  - Next state is IDLE.
- Timing: resp_valid is asserted exactly 1 cycle after the last frame bit is sampled.
- start asserted during DONE is ignored. A new start is accepted in IDLE only, i.e. at least one cycle after resp_valid.
- Timeout and frame/CRC errors are mutually exclusive. On timeout, crc_err=frame_err=0 and resp_data=0.

Optional Feature:
SD_CMD_RESP_CRC_CHECK_EN
- Defined: CRC7 is computed and compared as above.
- Undefined: no CRC logic is built and crc_err is tied to 0. R3 (OCR) frames, which carry no valid CRC, then never flag. Framing and timeout checks are unchanged.

Test Plan:
- Short R7 frame: arm with long_resp=0, idle cmd_in=1 for 5 cycles, then shift 0x08000001AA13 MSB first -> resp_valid 1 cycle after last bit; resp_data[47:0]=0x08000001AA13; crc_err=frame_err=timeout_err=0; busy low on the same cycle.
- CRC error: same frame with last byte 0x15 (CRC7 0x0A) -> resp_valid with crc_err=1 and frame_err=0; with the macro undefined, crc_err=0.
- Framing error: short frame with p1=1 (first byte 0x48, CRC recomputed) -> frame_err=1. A separate frame with end bit 0 -> frame_err=1.
- Timeout: arm and hold cmd_in=1 -> resp_valid and timeout_err=1 on the cycle after the 64th high sample; resp_data=0; a start pulse mid-wait is ignored.
- Long R2: arm with long_resp=1, send a 136-bit frame (header 0x3F, 120-bit CID, valid CRC7, end bit) -> resp_valid after bit 135; resp_data equals the frame; no errors; busy high for exactly 136 + wait cycles.
- Reset mid-frame: assert reset at p=20 of a short frame -> next edge all outputs 0, no resp_valid; a re-arm plus a full frame then completes normally.
